// File: rtl/pmod_cmd_if.sv
// Command front end between the Pico byte link and the AXI bus master:
// parses packets, issues write/read requests, returns read data and write acks.
module pmod_cmd_if #(
  parameter int unsigned MAX_BEATS = 128,
  parameter logic [7:0]  ACK_BYTE  = 8'hA5
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        write_req,
  output logic        write_bus_req,
  output logic        read_req,
  input  logic        busy,
  output logic [9:0]  len,
  output logic [31:0] address,
  output logic [63:0] wdata,
  input  logic [63:0] rdata,
  input  logic        rlast,
  output logic        error
);

  localparam int PW = $clog2(MAX_BEATS);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    IDLE, HDR, WDATA, WISSUE, WWAIT, ACK, RISSUE, RBEAT, TXDRAIN
  } state_e;

  state_e          state_q, state_d;
  logic            isWrite_q, isWrite_d;
  logic [2:0]      byteCnt_q, byteCnt_d;
  logic [CW-1:0]   wordCnt_q, wordCnt_d;
  logic [CW-1:0]   detCnt_q, detCnt_d;
  logic [CW-1:0]   pushCnt_q, pushCnt_d;
  logic            beatSeen_q, beatSeen_d;
  logic            wbHold_q;
  logic [9:0]      len_q, len_d;
  logic [31:0]     address_q, address_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            write_req_q, write_req_d;
  logic            write_bus_req_q, write_bus_req_d;
  logic            read_req_q, read_req_d;
  logic            error_q, error_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      txIdx_q, txIdx_d;
  logic            push, pop;
  logic [CW-1:0]   beats;
  logic [63:0]     curWord;
  logic [63:0]     fifoMem [MAX_BEATS];

  // A length code with a sub-word remainder is always a single beat.
  assign beats   = (len_q[2:0] == 3'd0) ? CW'(len_q[9:3]) + CW'(1) : CW'(1);
  assign curWord = fifoMem[rdPtr_q];

  always_comb begin
    state_d         = state_q;
    isWrite_d       = isWrite_q;
    byteCnt_d       = byteCnt_q;
    wordCnt_d       = wordCnt_q;
    detCnt_d        = detCnt_q;
    pushCnt_d       = pushCnt_q;
    len_d           = len_q;
    address_d       = address_q;
    wdata_d         = wdata_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    txIdx_d         = txIdx_q;
    write_req_d     = 1'b0;
    write_bus_req_d = 1'b0;
    read_req_d      = 1'b0;
    error_d         = 1'b0;
    beatSeen_d      = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    wrPtr_d         = wrPtr_q;
    rdPtr_d         = rdPtr_q;
    count_d         = count_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            isWrite_d = (rx_data == 8'h01);
            byteCnt_d = '0;
            wordCnt_d = '0;
            detCnt_d  = '0;
            pushCnt_d = '0;
            state_d   = HDR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (rx_valid) begin
          byteCnt_d = byteCnt_q + 3'd1;
          case (byteCnt_q)
            3'd0: address_d[7:0]   = rx_data;
            3'd1: address_d[15:8]  = rx_data;
            3'd2: address_d[23:16] = rx_data;
            3'd3: address_d[31:24] = rx_data;
            3'd4: len_d[7:0]       = rx_data;
            3'd5: begin
              len_d[9:8] = rx_data[1:0];
              byteCnt_d  = '0;
              state_d    = isWrite_q ? WDATA : RISSUE;
            end
            default: ;
          endcase
        end
      end
      WDATA: begin
        if (rx_valid) begin
          wdata_d   = {rx_data, wdata_q[63:8]};
          byteCnt_d = byteCnt_q + 3'd1;
          if (byteCnt_q == 3'd7) begin
            write_req_d = 1'b1;
            if (wordCnt_q + CW'(1) == beats) state_d = WISSUE;
            else wordCnt_d = wordCnt_q + CW'(1);
          end
        end
      end
      WISSUE: begin
        if (!busy) begin
          write_bus_req_d = 1'b1;
          state_d         = WWAIT;
        end
      end
      WWAIT: begin
        // The master may not have raised busy yet right after the request.
        if (!write_bus_req_q && !wbHold_q && !busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      RISSUE: begin
        if (!busy) begin
          read_req_d = 1'b1;
          state_d    = RBEAT;
        end
      end
      RBEAT: begin
        if (!read_req_q && !busy && detCnt_q != beats) begin
          beatSeen_d = 1'b1;
          detCnt_d   = detCnt_q + CW'(1);
        end
        if (beatSeen_q) begin
          push      = 1'b1;
          pushCnt_d = pushCnt_q + CW'(1);
          if (pushCnt_q + CW'(1) == beats) begin
            state_d = TXDRAIN;
          end else if (rlast) begin
            error_d = 1'b1;
            state_d = TXDRAIN;
          end
        end
      end
      TXDRAIN: begin
        if (count_q == '0 && (!tx_valid_q || tx_ready)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid && !(state_q inside {IDLE, HDR, WDATA})) error_d = 1'b1;

    // Serializer: one byte per cycle, lowest lane of each word first.
    if ((state_q == RBEAT || state_q == TXDRAIN) && (!tx_valid_q || tx_ready)) begin
      if (count_q != '0) begin
        tx_data_d  = curWord[{txIdx_q, 3'b000} +: 8];
        tx_valid_d = 1'b1;
        txIdx_d    = txIdx_q + 3'd1;
        if (txIdx_q == 3'd7) pop = 1'b1;
      end else begin
        tx_valid_d = 1'b0;
      end
    end

    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q         <= IDLE;
      isWrite_q       <= 1'b0;
      byteCnt_q       <= '0;
      wordCnt_q       <= '0;
      detCnt_q        <= '0;
      pushCnt_q       <= '0;
      beatSeen_q      <= 1'b0;
      wbHold_q        <= 1'b0;
      len_q           <= '0;
      address_q       <= '0;
      wdata_q         <= '0;
      write_req_q     <= 1'b0;
      write_bus_req_q <= 1'b0;
      read_req_q      <= 1'b0;
      error_q         <= 1'b0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      wrPtr_q         <= '0;
      rdPtr_q         <= '0;
      count_q         <= '0;
      txIdx_q         <= '0;
    end else begin
      state_q         <= state_d;
      isWrite_q       <= isWrite_d;
      byteCnt_q       <= byteCnt_d;
      wordCnt_q       <= wordCnt_d;
      detCnt_q        <= detCnt_d;
      pushCnt_q       <= pushCnt_d;
      beatSeen_q      <= beatSeen_d;
      wbHold_q        <= write_bus_req_q;
      len_q           <= len_d;
      address_q       <= address_d;
      wdata_q         <= wdata_d;
      write_req_q     <= write_req_d;
      write_bus_req_q <= write_bus_req_d;
      read_req_q      <= read_req_d;
      error_q         <= error_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      wrPtr_q         <= wrPtr_d;
      rdPtr_q         <= rdPtr_d;
      count_q         <= count_d;
      txIdx_q         <= txIdx_d;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (push) fifoMem[wrPtr_q] <= rdata;
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign write_req     = write_req_q;
  assign write_bus_req = write_bus_req_q;
  assign read_req      = read_req_q;
  assign len           = len_q;
  assign address       = address_q;
  assign wdata         = wdata_q;
  assign error         = error_q;

endmodule

// File: tb/tb_pmod_cmd_if.sv
// Randomized scoreboard bench for pmod_cmd_if with a simple bus master
// model; expectations come from the packet rules, not from the RTL.
module tb_pmod_cmd_if;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        busy = 1'b0;
  logic [63:0] rdata = 64'h0;
  logic        rlast = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid, write_req, write_bus_req, read_req, error;
  logic [9:0]  len;
  logic [31:0] address;
  logic [63:0] wdata;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] expWr[$];
  logic [7:0]  expTx[$];
  logic [63:0] rdWordsQ[$];
  logic [7:0]  payloadQ[$];
  logic [63:0] rdIn[$];
  int expWrBus = 0, expRdReq = 0, expErr = 0;
  int nWrBus = 0, nRdReq = 0, nErr = 0;
  logic [31:0] expAddr = 32'h0;
  logic [9:0]  expLen = 10'h0;
  logic [63:0] lastWord = 64'h0;
  int txReadyMode = 0;
  int gapMax = 1;
  logic forceBusy = 1'b0;

  pmod_cmd_if dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .write_req(write_req), .write_bus_req(write_bus_req), .read_req(read_req),
    .busy(busy), .len(len), .address(address), .wdata(wdata),
    .rdata(rdata), .rlast(rlast), .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic int beatsOf(input logic [9:0] l);
    return (l % 8 == 0) ? int'(l) / 8 + 1 : 1;
  endfunction

  // Bus master model: reacts one cycle after seeing a request.
  int wrBusyCnt = 0;
  bit rdActive = 0;
  bit pendValid = 0;
  bit pendLast = 0;
  logic [63:0] pendWord = 64'h0;
  int cyc = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pendValid) begin
        rdata = pendWord;
        rlast = pendLast;
        pendValid = 0;
      end else begin
        rlast = 1'b0;
      end
      if (wrBusyCnt > 0) begin
        busy = 1'b1;
        wrBusyCnt--;
      end else if (rdActive && rdWordsQ.size() != 0) begin
        if ($urandom_range(0, 2) == 0) begin
          busy = 1'b1;
        end else begin
          busy = 1'b0;
          pendLast = (rdWordsQ.size() == 1);
          pendWord = rdWordsQ.pop_front();
          pendValid = 1;
        end
      end else begin
        busy = 1'b0;
        rdActive = 0;
      end
      busy = busy | forceBusy;
      case (txReadyMode)
        0: tx_ready = 1'b1;
        1: tx_ready = cyc[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset) begin
        wrBusyCnt = 0;
        rdActive = 0;
        pendValid = 0;
      end else begin
        if (write_bus_req) wrBusyCnt = 2 + $urandom_range(0, 3);
        if (read_req) rdActive = 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  logic prevBusy = 1'b0, prevTxValid = 1'b0, prevTxReady = 1'b0;
  logic [7:0] prevTxData = 8'h0;
  always @(negedge clk) begin
    logic [63:0] w;
    logic [7:0] b;
    if (reset) begin
      prevTxValid = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (write_req || write_bus_req || read_req)
        checkOutput("single request per cycle", 64'($countones({write_req, write_bus_req, read_req})), 64'd1);
      if (write_req) begin
        if (expWr.size() == 0) checkOutput("unexpected write_req", 64'd1, 64'd0);
        else begin
          w = expWr.pop_front();
          lastWord = w;
          checkOutput("write_req wdata", wdata, w);
        end
      end
      if (write_bus_req) begin
        nWrBus++;
        checkOutput("write_bus_req busy before", 64'(prevBusy), 64'd0);
        checkOutput("write_bus_req wdata", wdata, lastWord);
        checkOutput("write_bus_req address", 64'(address), 64'(expAddr));
        checkOutput("write_bus_req len", 64'(len), 64'(expLen));
      end
      if (read_req) begin
        nRdReq++;
        checkOutput("read_req busy before", 64'(prevBusy), 64'd0);
        checkOutput("read_req address", 64'(address), 64'(expAddr));
        checkOutput("read_req len", 64'(len), 64'(expLen));
      end
      if (error) nErr++;
      if (prevTxValid && !prevTxReady) begin
        checkOutput("tx_valid held", 64'(tx_valid), 64'd1);
        checkOutput("tx_data held", 64'(tx_data), 64'(prevTxData));
      end
      if (tx_valid && tx_ready) begin
        if (expTx.size() == 0) checkOutput("unexpected tx byte", 64'(tx_data), 64'hFFFF);
        else begin
          b = expTx.pop_front();
          checkOutput("tx byte", 64'(tx_data), 64'(b));
        end
      end
      prevTxValid = tx_valid;
      prevTxReady = tx_ready;
      prevTxData = tx_data;
      prevBusy = busy;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, gapMax)) begin
      @(posedge clk); #1;
    end
  endtask

  // Builds one packet, records its expected responses, then sends it.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [9:0] ln);
    int nb;
    logic [63:0] word;
    nb = beatsOf(ln);
    expAddr = addr;
    expLen = ln;
    if (isWrite) begin
      if (payloadQ.size() == 0)
        for (int i = 0; i < 8 * nb; i++) payloadQ.push_back(8'($urandom));
      for (int wi = 0; wi < nb; wi++) begin
        word = 64'h0;
        for (int bi = 0; bi < 8; bi++) word = word | (64'(payloadQ[8 * wi + bi]) << (8 * bi));
        expWr.push_back(word);
      end
      expTx.push_back(8'hA5);
      expWrBus++;
    end else begin
      if (rdIn.size() == 0)
        for (int i = 0; i < nb; i++) rdIn.push_back({$urandom, $urandom});
      foreach (rdIn[i]) begin
        rdWordsQ.push_back(rdIn[i]);
        for (int bi = 0; bi < 8; bi++) expTx.push_back(8'(rdIn[i] >> (8 * bi)));
      end
      expRdReq++;
    end
    sendByte(isWrite ? 8'h01 : 8'h02);
    for (int i = 0; i < 4; i++) sendByte(8'(addr >> (8 * i)));
    sendByte(ln[7:0]);
    sendByte({6'($urandom), ln[9:8]});
    if (isWrite) foreach (payloadQ[i]) sendByte(payloadQ[i]);
    payloadQ.delete();
    rdIn.delete();
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((expTx.size() != 0 || expWr.size() != 0) && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 12000) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL completion timeout: %0d tx bytes outstanding, expected 0", expTx.size());
      expTx.delete();
      expWr.delete();
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("tx_valid idle", 64'(tx_valid), 64'd0);
    checkOutput("write_bus_req count", 64'(nWrBus), 64'(expWrBus));
    checkOutput("read_req count", 64'(nRdReq), 64'(expRdReq));
    checkOutput("error count", 64'(nErr), 64'(expErr));
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("reset write_req", 64'(write_req), 64'd0);
    checkOutput("reset write_bus_req", 64'(write_bus_req), 64'd0);
    checkOutput("reset read_req", 64'(read_req), 64'd0);
    checkOutput("reset error", 64'(error), 64'd0);
    checkOutput("reset tx_data", 64'(tx_data), 64'd0);
    checkOutput("reset len", 64'(len), 64'd0);
    checkOutput("reset address", 64'(address), 64'd0);
    checkOutput("reset wdata", wdata, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single-beat write");
    for (int i = 1; i <= 8; i++) payloadQ.push_back(8'(i * 8'h11));
    applyStimulus(1'b1, 32'h1000_0004, 10'd4);
    waitDone();

    $display("[TB] burst write with busy held");
    forceBusy = 1'b1;
    applyStimulus(1'b1, 32'h2000_0040, 10'd8);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("write_bus_req held off while busy", 64'(nWrBus), 64'(expWrBus - 1));
    forceBusy = 1'b0;
    waitDone();

    $display("[TB] single-beat read");
    rdIn.push_back(64'h0102030405060708);
    applyStimulus(1'b0, 32'h3000_0000, 10'd0);
    waitDone();

    $display("[TB] 3-beat read with slow tx_ready, then single read");
    txReadyMode = 1;
    applyStimulus(1'b0, 32'h3000_0100, 10'd16);
    waitDone();
    txReadyMode = 0;
    applyStimulus(1'b0, 32'h3000_0200, 10'd0);
    waitDone();

    $display("[TB] bad opcode then read");
    expErr++;
    sendByte(8'h7F);
    applyStimulus(1'b0, 32'h4000_0008, 10'd8);
    waitDone();

    $display("[TB] reset during burst write payload");
    sendByte(8'h01);
    for (int i = 0; i < 4; i++) sendByte(8'h5A);
    sendByte(8'd8);
    sendByte(8'd0);
    for (int i = 0; i < 3; i++) sendByte(8'($urandom));
    reset = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h5000_0000, 10'd8);
    waitDone();

    $display("[TB] randomized transactions");
    txReadyMode = 2;
    applyStimulus(1'b0, 32'h6000_0000, 10'd1016);
    waitDone();
    for (int t = 0; t < 8; t++) begin
      logic [9:0] ln;
      case ($urandom_range(0, 3))
        0: ln = 10'($urandom_range(0, 1023));
        1: ln = 10'(8 * $urandom_range(0, 15));
        2: ln = 10'($urandom_range(1, 7));
        default: ln = 10'd1016;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), $urandom, ln);
      waitDone();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(800_000);
    mismatched++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
